simple_writeback: RTL and testbench

//  Write-back stage of the SIMPLE 16-bit pipeline, fed by the memory-access stage.

---
 rtl/simple_pkg.sv | 13 +
 rtl/simple_writeback_if.sv | 37 +++
 rtl/simple_regfile.sv | 54 +++++
 rtl/simple_writeback.sv | 67 ++++++
 tb/tb_simple_writeback.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/simple_pkg.sv
// Shared constants and types for the SIMPLE 16-bit pipeline write-back stage.
package simple_pkg;

    localparam int DATA_W   = 16;
    localparam int RADDR_W  = 3;
    localparam int NUM_REGS = 1 << RADDR_W;
    localparam int CNT_W    = 16;

    typedef logic [DATA_W-1:0]  word_t;
    typedef logic [RADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]   cnt_t;

endpackage

// File: rtl/simple_writeback_if.sv
// Bus between the memory-access stage / register readers and the write-back stage.
interface simple_writeback_if;
    import simple_pkg::*;

    // Instruction arriving from the memory-access stage
    logic      wbValid;
    word_t     readOutData;
    word_t     aluResult;
    logic      memToReg;
    logic      WriteReg;
    reg_addr_t RegAddress;

    // Register read ports
    reg_addr_t rsAddr;
    reg_addr_t rtAddr;
    word_t     rsData;
    word_t     rtData;

    // Forwarding tap and retire counter
    logic      fwdValid;
    reg_addr_t fwdAddr;
    word_t     fwdData;
    cnt_t      retireCount;

    modport master (
        output wbValid, readOutData, aluResult, memToReg, WriteReg, RegAddress,
        output rsAddr, rtAddr,
        input  rsData, rtData, fwdValid, fwdAddr, fwdData, retireCount
    );

    modport slave (
        input  wbValid, readOutData, aluResult, memToReg, WriteReg, RegAddress,
        input  rsAddr, rtAddr,
        output rsData, rtData, fwdValid, fwdAddr, fwdData, retireCount
    );

endinterface

// File: rtl/simple_regfile.sv
// 8x16 register file: one synchronous write port, two combinational read ports
// with write-through bypass so a reader sees the value being committed this cycle.
module simple_regfile
    import simple_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    input  logic      we,
    input  reg_addr_t waddr,
    input  word_t     wdata,
    input  reg_addr_t ra_addr,
    input  reg_addr_t rb_addr,
    output word_t     ra_data,
    output word_t     rb_data
);

    word_t                regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0]  wr_sel;

    // One-hot write decode; every register is writable, none hardwired.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
            assign wr_sel[gi] = we && (waddr == reg_addr_t'(gi));
        end
    endgenerate

    // Register storage: cleared on reset, otherwise the decoded entry takes wdata.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs_reg[i] <= wdata;
                end
            end
        end
    end

    // Read ports with same-cycle bypass of the pending write.
    always_comb begin
        ra_data = regs_reg[ra_addr];
        rb_data = regs_reg[rb_addr];
        if (we && (ra_addr == waddr)) begin
            ra_data = wdata;
        end
        if (we && (rb_addr == waddr)) begin
            rb_data = wdata;
        end
    end

endmodule

// File: rtl/simple_writeback.sv
// Write-back stage: picks load data or ALU result, commits it to the register
// file, exposes a one-cycle forwarding tap and counts retired instructions.
module simple_writeback
    import simple_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    simple_writeback_if.slave bus
);

    logic      commit;
    word_t     wdata;
    logic      fwd_valid_reg;
    reg_addr_t fwd_addr_reg;
    word_t     fwd_data_reg;
    cnt_t      retire_reg;

    // Reset gates the commit so an in-flight instruction is discarded and the
    // read ports show stored values without bypass while reset is held.
    // The ternary keeps the unselected (possibly X) source out of wdata.
    always_comb begin
        commit = reset_n && bus.wbValid && bus.WriteReg;
        wdata  = bus.memToReg ? bus.readOutData : bus.aluResult;
    end

    simple_regfile u_regfile (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (commit),
        .waddr   (bus.RegAddress),
        .wdata   (wdata),
        .ra_addr (bus.rsAddr),
        .rb_addr (bus.rtAddr),
        .ra_data (bus.rsData),
        .rb_data (bus.rtData)
    );

    // Forwarding tap: valid pulses for one cycle per commit, addr/data hold otherwise.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fwd_valid_reg <= 1'b0;
            fwd_addr_reg  <= '0;
            fwd_data_reg  <= '0;
        end else begin
            fwd_valid_reg <= commit;
            if (commit) begin
                fwd_addr_reg <= bus.RegAddress;
                fwd_data_reg <= wdata;
            end
        end
    end

    // Retire counter: every valid WB cycle counts, including non-writing ones; wraps.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            retire_reg <= '0;
        end else if (bus.wbValid) begin
            retire_reg <= retire_reg + cnt_t'(1);
        end
    end

    assign bus.fwdValid    = fwd_valid_reg;
    assign bus.fwdAddr     = fwd_addr_reg;
    assign bus.fwdData     = fwd_data_reg;
    assign bus.retireCount = retire_reg;

endmodule

// File: tb/tb_simple_writeback.sv
// Self-checking bench for simple_writeback: directed vector table, random
// traffic against a register-array reference model, and a counter wrap run.
module tb_simple_writeback;
    import simple_pkg::*;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    simple_writeback_if bus ();

    simple_writeback dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic      rn;
        logic      v;
        logic      mtr;
        logic      we;
        reg_addr_t a;
        word_t     rd;
        word_t     al;
        reg_addr_t rs;
        reg_addr_t rt;
    } stim_t;

    typedef struct {
        stim_t s;
        word_t ers;
        word_t ert;
        logic  efv;
        word_t efd;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    int n_tick   = 0;

    // Reference model state
    word_t     regs_m [NUM_REGS];
    int        cnt_m;
    logic      fv_m;
    reg_addr_t fa_m;
    word_t     fd_m;

    function automatic stim_t mk_s(logic rn, logic v, logic mtr, logic we, reg_addr_t a,
                                   word_t rd, word_t al, reg_addr_t rs, reg_addr_t rt);
        stim_t s;
        s.rn = rn; s.v = v; s.mtr = mtr; s.we = we; s.a = a;
        s.rd = rd; s.al = al; s.rs = rs; s.rt = rt;
        return s;
    endfunction

    function automatic vec_t mk_v(stim_t s, word_t ers, word_t ert, logic efv, word_t efd);
        vec_t v;
        v.s = s; v.ers = ers; v.ert = ert; v.efv = efv; v.efd = efd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply(input stim_t s);
        reset_n         = s.rn;
        bus.wbValid     = s.v;
        bus.memToReg    = s.mtr;
        bus.WriteReg    = s.we;
        bus.RegAddress  = s.a;
        bus.readOutData = s.rd;
        bus.aluResult   = s.al;
        bus.rsAddr      = s.rs;
        bus.rtAddr      = s.rt;
    endtask

    function automatic word_t model_read(stim_t s, reg_addr_t addr);
        logic  c;
        word_t wd;
        c  = s.rn && s.v && s.we;
        wd = s.mtr ? s.rd : s.al;
        if (c && addr == s.a) return wd;
        return regs_m[addr];
    endfunction

    task automatic model_step(input stim_t s);
        logic  c;
        word_t wd;
        c  = s.rn && s.v && s.we;
        wd = s.mtr ? s.rd : s.al;
        if (!s.rn) begin
            for (int i = 0; i < NUM_REGS; i++) regs_m[i] = '0;
            cnt_m = 0;
            fv_m  = 1'b0;
            fa_m  = '0;
            fd_m  = '0;
        end else begin
            if (c) begin
                regs_m[s.a] = wd;
                fa_m = s.a;
                fd_m = wd;
            end
            fv_m = c;
            if (s.v) cnt_m = (cnt_m + 1) % 65536;
        end
    endtask

    // One transaction: drive at posedge+1, check reads at negedge, check
    // registered outputs 1 time unit after the following posedge.
    task automatic tick(input stim_t s, input bit has_exp, input word_t ers, input word_t ert,
                        input logic efv, input word_t efd);
        apply(s);
        @(negedge clock);
        check("rsData_model", {16'h0, bus.rsData}, {16'h0, model_read(s, s.rs)});
        check("rtData_model", {16'h0, bus.rtData}, {16'h0, model_read(s, s.rt)});
        if (has_exp) begin
            check("rsData_vec", {16'h0, bus.rsData}, {16'h0, ers});
            check("rtData_vec", {16'h0, bus.rtData}, {16'h0, ert});
        end
        @(posedge clock);
        model_step(s);
        #1;
        check("fwdValid", {31'h0, bus.fwdValid}, {31'h0, fv_m});
        check("fwdAddr", {29'h0, bus.fwdAddr}, {29'h0, fa_m});
        check("fwdData", {16'h0, bus.fwdData}, {16'h0, fd_m});
        check("retireCount", {16'h0, bus.retireCount}, cnt_m);
        if (has_exp) begin
            check("fwdValid_vec", {31'h0, bus.fwdValid}, {31'h0, efv});
            check("fwdData_vec", {16'h0, bus.fwdData}, {16'h0, efd});
        end
        $display("txn %0d rn=%b v=%b we=%b a=%0d rs=%0d:%h rt=%0d:%h fwd=%b/%0d/%h cnt=%0d",
                 n_tick, s.rn, s.v, s.we, s.a, s.rs, bus.rsData, s.rt, bus.rtData,
                 bus.fwdValid, bus.fwdAddr, bus.fwdData, bus.retireCount);
        n_tick++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs [15];
        stim_t s;

        // Directed vectors: reset, ALU write, load bypass, store/bubble, mid-stream reset, back-to-back
        vecs[0]  = mk_v(mk_s(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0000, 16'h5555, 3'd1, 3'd1), 16'h0000, 16'h0000, 1'b0, 16'h0000);
        vecs[1]  = mk_v(mk_s(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0000, 16'h5555, 3'd1, 3'd1), 16'h0000, 16'h0000, 1'b0, 16'h0000);
        vecs[2]  = mk_v(mk_s(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0000, 16'h5555, 3'd0, 3'd7), 16'h0000, 16'h0000, 1'b0, 16'h0000);
        vecs[3]  = mk_v(mk_s(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd2, 3'd4), 16'h0000, 16'h0000, 1'b0, 16'h0000);
        vecs[4]  = mk_v(mk_s(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 16'hDEAD, 16'h1234, 3'd0, 3'd0), 16'h0000, 16'h0000, 1'b1, 16'h1234);
        vecs[5]  = mk_v(mk_s(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd3, 3'd3), 16'h1234, 16'h1234, 1'b0, 16'h1234);
        vecs[6]  = mk_v(mk_s(1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 16'hBEEF, 16'h0000, 3'd5, 3'd5), 16'hBEEF, 16'hBEEF, 1'b1, 16'hBEEF);
        vecs[7]  = mk_v(mk_s(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd5, 3'd3), 16'hBEEF, 16'h1234, 1'b0, 16'hBEEF);
        vecs[8]  = mk_v(mk_s(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0000, 16'hFFFF, 3'd3, 3'd5), 16'h1234, 16'hBEEF, 1'b0, 16'hBEEF);
        vecs[9]  = mk_v(mk_s(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd3, 3'd3), 16'h1234, 16'h1234, 1'b0, 16'hBEEF);
        vecs[10] = mk_v(mk_s(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0000, 16'h00AA, 3'd2, 3'd3), 16'h0000, 16'h1234, 1'b0, 16'h0000);
        vecs[11] = mk_v(mk_s(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd2, 3'd3), 16'h0000, 16'h0000, 1'b0, 16'h0000);
        vecs[12] = mk_v(mk_s(1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 16'h0000, 16'h0001, 3'd7, 3'd2), 16'h0001, 16'h0000, 1'b1, 16'h0001);
        vecs[13] = mk_v(mk_s(1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 16'h0000, 16'h0002, 3'd7, 3'd7), 16'h0002, 16'h0002, 1'b1, 16'h0002);
        vecs[14] = mk_v(mk_s(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd7, 3'd0), 16'h0002, 16'h0000, 1'b0, 16'h0002);

        // Unchecked preamble reset to bring DUT and model to a known state
        s = mk_s(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 3'd0);
        apply(s);
        @(posedge clock);
        model_step(s);
        #1;

        for (int i = 0; i < 15; i++) begin
            tick(vecs[i].s, 1'b1, vecs[i].ers, vecs[i].ert, vecs[i].efv, vecs[i].efd);
        end

        // Random traffic against the reference model, with occasional resets
        for (int i = 0; i < 300; i++) begin
            s = mk_s(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            tick(s, 1'b0, '0, '0, 1'b0, '0);
        end

        // Counter wrap: reset, 65535 non-writing valid cycles, then one more
        s = mk_s(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 3'd0);
        tick(s, 1'b0, '0, '0, 1'b0, '0);
        s = mk_s(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 16'h0, 16'h7777, 3'd4, 3'd0);
        apply(s);
        repeat (65535) @(posedge clock);
        #1;
        check("retire_preload", {16'h0, bus.retireCount}, 32'h0000_FFFF);
        $display("txn %0d preload 65535 valid cycles cnt=%h", n_tick, bus.retireCount);
        n_tick++;
        cnt_m = 65535;
        fv_m  = 1'b0;
        tick(s, 1'b0, '0, '0, 1'b0, '0);
        check("retire_wrap", {16'h0, bus.retireCount}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
